// File: rtl/fir_coeff_loader.sv
// Framed coefficient loader: fills a shadow bank over valid/ready, then commits all taps at once.
// Define FIR_COEFF_CHECKSUM_EN to require a trailing checksum word per frame.
//
// state  | meaning
// IDLE   | waiting for i_start, input words ignored
// LOAD   | accepting coefficient words into the shadow bank
// CHECK  | checksum build only: waiting for the checksum word
// COMMIT | one cycle, copies shadow bank into the active bank
module fir_coeff_loader #(
    parameter int FILTER_LENGTH     = 8,
    parameter int COEFFICIENT_WIDTH = 16
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  i_start,
    input  logic signed [COEFFICIENT_WIDTH-1:0]                   i_coef,
    input  logic                                                  i_valid,
    output logic                                                  o_ready,
    output logic signed [FILTER_LENGTH-1:0][COEFFICIENT_WIDTH-1:0] o_coefficients,
    output logic                                                  o_busy,
    output logic                                                  o_update,
    output logic                                                  o_error
);

    localparam int IDX_W = $clog2(FILTER_LENGTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILTER_LENGTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
`ifdef FIR_COEFF_CHECKSUM_EN
    localparam logic [1:0] S_CHECK  = 2'd3;
`endif

    logic [1:0]                         state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               update_q, update_d;
    logic [COEFFICIENT_WIDTH-1:0]       shadow_q [FILTER_LENGTH];
    logic [FILTER_LENGTH-1:0][COEFFICIENT_WIDTH-1:0] active_q;
    logic                               shadow_we;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic [COEFFICIENT_WIDTH-1:0]       sum_q, sum_d;
    logic                               error_q, error_d;
`endif

    // i_start wins over a simultaneous word, so that word never reaches the shadow bank.
    assign shadow_we = (state_q == S_LOAD) && i_valid && !i_start;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        update_d = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
        sum_d    = sum_q;
        error_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LOAD: begin
                if (i_start) begin
                    idx_d = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d = '0;
`endif
                end else if (i_valid) begin
                    idx_d = idx_q + IDX_W'(1);
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d = sum_q + i_coef;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CHECK;
                    end
`else
                    if (idx_q == LAST_IDX) begin
                        state_d = S_COMMIT;
                    end
`endif
                end
            end
`ifdef FIR_COEFF_CHECKSUM_EN
            S_CHECK: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                end else if (i_valid) begin
                    if (i_coef == sum_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            S_COMMIT: begin
                state_d  = S_IDLE;
                update_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            update_q <= 1'b0;
            active_q <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q    <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            update_q <= update_d;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q    <= sum_d;
            error_q  <= error_d;
`endif
            if (state_q == S_COMMIT) begin
                for (int i = 0; i < FILTER_LENGTH; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Shadow bank carries no reset; it is always fully rewritten before a commit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FILTER_LENGTH; i++) begin
            if (shadow_we && (idx_q == IDX_W'(i))) begin
                shadow_q[i] <= i_coef;
            end
        end
    end

    assign o_ready        = (state_q == S_LOAD)
`ifdef FIR_COEFF_CHECKSUM_EN
                          || (state_q == S_CHECK)
`endif
                          ;
    assign o_busy         = (state_q != S_IDLE);
    assign o_update       = update_q;
    assign o_coefficients = active_q;
`ifdef FIR_COEFF_CHECKSUM_EN
    assign o_error        = error_q;
`else
    assign o_error        = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader (FILTER_LENGTH=4, COEFFICIENT_WIDTH=16).
// Build with FIR_COEFF_CHECKSUM_EN defined to also exercise the checksum frames.
module tb_fir_coeff_loader;

    typedef logic [3:0][15:0] bank_t;
    typedef struct {
        bit    is_err;
        bank_t coefs;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_coef;
    logic        i_valid;
    logic        o_ready;
    bank_t       o_coefficients;
    logic        o_busy;
    logic        o_update;
    logic        o_error;

    int    checks = 0;
    int    errors = 0;
    int    pulse_cnt = 0;
    exp_t  sb_q[$];
    exp_t  mon_e;
    bank_t model_active;

    fir_coeff_loader #(
        .FILTER_LENGTH    (4),
        .COEFFICIENT_WIDTH(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_coef        (i_coef),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_coefficients(o_coefficients),
        .o_busy        (o_busy),
        .o_update      (o_update),
        .o_error       (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic bank_t mk(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
        bank_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = d;
        return r;
    endfunction

    // Monitor: every update/error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (o_update || o_error)) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: update=%0b error=%0b, expected no pulse", o_update, o_error);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_is_update", {63'd0, o_update}, {63'd0, !mon_e.is_err});
                check("pulse_is_error", {63'd0, o_error}, {63'd0, mon_e.is_err});
                check("active_bank_at_pulse", o_coefficients, mon_e.coefs);
            end
        end
    end

    task automatic start_frame();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input bit gap);
        i_valid = 1'b1;
        i_coef  = w;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_coef  = 16'h0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_frame(input bank_t c, input bit gap, input bit skip_start,
                              input logic [15:0] chk, input bit use_chk);
        logic [15:0] sum;
        bit          match;
        int          p0;
        bit          last_gap;
        sum = 16'h0;
        p0  = pulse_cnt;
        for (int i = 0; i < 4; i++) sum = sum + c[i];
        match = 1'b1;
`ifdef FIR_COEFF_CHECKSUM_EN
        if (use_chk) match = (chk == sum);
        last_gap = gap;
`else
        last_gap = 1'b0;
`endif
        if (!skip_start) start_frame();
        check("ready_in_load", {63'd0, o_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            send(c[i], (i < 3) ? gap : last_gap);
            check("active_hidden_during_load", o_coefficients, model_active);
        end
`ifdef FIR_COEFF_CHECKSUM_EN
        send(use_chk ? chk : sum, 1'b0);
`endif
        if (match) begin
            sb_q.push_back('{is_err: 1'b0, coefs: c});
            check("no_update_before_commit", {63'd0, o_update}, 64'd0);
            @(posedge clk);
            #1;
            check("update_latency", {63'd0, o_update}, 64'd1);
            model_active = c;
        end else begin
            sb_q.push_back('{is_err: 1'b1, coefs: model_active});
            check("error_latency", {63'd0, o_error}, 64'd1);
        end
        check("busy_after_frame", {63'd0, o_busy}, 64'd0);
        @(posedge clk);
        #1;
        check("pulse_one_cycle", {62'd0, o_update, o_error}, 64'd0);
        check("pulse_count_per_frame", 64'(pulse_cnt - p0), 64'd1);
        check("active_after_frame", o_coefficients, model_active);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_valid      = 1'b0;
        i_coef       = 16'h0;
        model_active = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_coefficients", o_coefficients, 64'd0);
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_update", {63'd0, o_update}, 64'd0);
        check("rst_error", {63'd0, o_error}, 64'd0);
        rst = 1'b0;

        // Words offered in IDLE are ignored
        i_valid = 1'b1;
        i_coef  = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("idle_valid_ignored_coefs", o_coefficients, 64'd0);
        check("idle_valid_ignored_busy", {63'd0, o_busy}, 64'd0);
        check("idle_valid_ignored_ready", {63'd0, o_ready}, 64'd0);

        // Basic back-to-back load
        load_frame(mk(16'd1, 16'd2, 16'd3, 16'd4), 1'b0, 1'b0, 16'h0, 1'b0);
        check("basic_bank", o_coefficients, 64'h0004_0003_0002_0001);

        // Throttled load with extreme values
        load_frame(mk(16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h8000), 1'b1, 1'b0, 16'h0, 1'b0);
        check("extremes_bank", o_coefficients, 64'h8000_7FFF_FFFE_FFFF);

        // Abort and restart: restart edge also carries a word that must be dropped
        p0 = pulse_cnt;
        start_frame();
        send(16'd9, 1'b0);
        send(16'd9, 1'b0);
        i_start = 1'b1;
        i_valid = 1'b1;
        i_coef  = 16'd9;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_valid = 1'b0;
        check("abort_no_pulse", 64'(pulse_cnt - p0), 64'd0);
        check("abort_still_busy", {63'd0, o_busy}, 64'd1);
        load_frame(mk(16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 1'b1, 16'h0, 1'b0);
        check("abort_bank", o_coefficients, 64'h0008_0007_0006_0005);

        // Reset in the middle of a frame
        start_frame();
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_active = '0;
        check("midrst_coefs", o_coefficients, 64'd0);
        check("midrst_busy", {63'd0, o_busy}, 64'd0);
        check("midrst_ready", {63'd0, o_ready}, 64'd0);
        load_frame(mk(16'd1, 16'd2, 16'd3, 16'd4), 1'b0, 1'b0, 16'h0, 1'b0);
        check("post_rst_bank", o_coefficients, 64'h0004_0003_0002_0001);

`ifdef FIR_COEFF_CHECKSUM_EN
        load_frame(mk(16'd1, 16'd2, 16'd3, 16'd4), 1'b0, 1'b0, 16'd10, 1'b1);
        check("chk_good_bank", o_coefficients, 64'h0004_0003_0002_0001);
        load_frame(mk(16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 1'b0, 16'd27, 1'b1);
        check("chk_bad_bank_kept", o_coefficients, 64'h0004_0003_0002_0001);
        load_frame(mk(16'h7FFF, 16'd1, 16'd0, 16'd0), 1'b0, 1'b0, 16'h8000, 1'b1);
        check("chk_wrap_bank", o_coefficients, 64'h0000_0000_0001_7FFF);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
